// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: slave FSM state encoding and the byte-offset width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wishbone_pkg;

    // Slave FSM state encoding, kept as plain constants so older tools that do
    // not support enums in ports can still consume it.
    typedef logic [1:0] wb_slave_state_t;

    localparam wb_slave_state_t IDLE = 2'd0;
    localparam wb_slave_state_t WAIT = 2'd1;
    localparam wb_slave_state_t ACK  = 2'd2;

    // Number of low address bits that select a byte within a bus word.
    function automatic int byte_off_width(input int sel_width);
        return (sel_width > 1) ? $clog2(sel_width) : 0;
    endfunction

endpackage

// File: rtl/wishbone_bus_if.sv
// Wishbone classic bus bundle with master and slave views.
// Latency: n/a (wires only).
// Backpressure: slave holds off the master by withholding ack.
interface wishbone_bus_if #(
    parameter int adr_width = 32,
    parameter int dat_width = 32,
    parameter int sel_width = dat_width / 8
) ();
    logic [adr_width-1:0] adr;
    logic [dat_width-1:0] datwr;
    logic [sel_width-1:0] sel;
    logic                 we;
    logic                 stb;
    logic                 cyc;
    logic [dat_width-1:0] datrd;
    logic                 ack;

    modport s_modport (
        input  adr, datwr, sel, we, stb, cyc,
        output datrd, ack
    );

    modport m_modport (
        output adr, datwr, sel, we, stb, cyc,
        input  datrd, ack
    );
endinterface

// File: rtl/wb_sram_array.sv
// Word-addressed SRAM, one byte-enabled write port and one registered read port.
// Latency: read data appears the cycle after re; writes land on the clock edge.
// Backpressure: none, accepts a write and/or read every cycle.
// Ports: clock/reset; we, be, wadr, wdat (write); re, radr -> rdat (read).
// rdat returns to zero in every cycle that follows a cycle without re.
module wb_sram_array #(
    parameter int dat_width = 32,
    parameter int sel_width = dat_width / 8,
    parameter int depth     = 256
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       we,
    input  logic [sel_width-1:0]       be,
    input  logic [$clog2(depth)-1:0]   wadr,
    input  logic [dat_width-1:0]       wdat,
    input  logic                       re,
    input  logic [$clog2(depth)-1:0]   radr,
    output logic [dat_width-1:0]       rdat
);

    logic [dat_width-1:0] mem_q [depth];
    logic [dat_width-1:0] rdat_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < sel_width; b++) begin
                if (be[b]) begin
                    mem_q[wadr][8*b +: 8] <= wdat[8*b +: 8];
                end
            end
        end
    end

    // The read flop doubles as the bus datrd register, so it clears whenever
    // no read was issued in the previous cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdat_q <= '0;
        end else if (re) begin
            rdat_q <= mem_q[radr];
        end else begin
            rdat_q <= '0;
        end
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave fronting an SRAM with byte-lane writes and programmable wait states.
// Latency: ack wait_states+1 cycles after the request is sampled in IDLE.
// Backpressure: one outstanding request; master is stalled by withholding ack.
// Ports: clock, reset (sync, active-high); bus = Wishbone slave view
// (adr/datwr/sel/we/stb/cyc in, datrd/ack out, both outputs registered).
module wb_sram_slave
    import wishbone_pkg::*;
#(
    parameter int                   adr_width   = 32,
    parameter int                   dat_width   = 32,
    parameter int                   sel_width   = dat_width / 8,
    parameter int                   depth       = 256,
    parameter int                   wait_states = 1,
    parameter logic [adr_width-1:0] base_adr    = '0
) (
    input  logic               clock,
    input  logic               reset,
    wishbone_bus_if.s_modport  bus
);

    localparam int         bow     = byte_off_width(sel_width);
    localparam int         aw      = $clog2(depth);
    localparam logic [3:0] ws_load = 4'(wait_states - 1);

    typedef logic [aw-1:0] idx_t;

    wb_slave_state_t      state_q, state_d;
    logic [3:0]           cnt_q,   cnt_d;
    idx_t                 idx_q,   idx_d;
    logic                 we_q,    we_d;
    logic [dat_width-1:0] dat_q,   dat_d;
    logic [sel_width-1:0] sel_q,   sel_d;
    logic                 ack_q,   ack_d;

    idx_t                 bus_idx;
    idx_t                 arr_radr;
    logic                 arr_re;
    logic                 arr_we;
    logic [dat_width-1:0] arr_rdat;

    // Truncating the cast keeps only the low index bits, so addresses wrap.
    assign bus_idx = idx_t'((bus.adr - base_adr) >> bow);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        we_d     = we_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        arr_re   = 1'b0;
        arr_radr = idx_q;

        case (state_q)
            IDLE: begin
                if (bus.cyc && bus.stb) begin
                    idx_d = bus_idx;
                    we_d  = bus.we;
                    dat_d = bus.datwr;
                    sel_d = bus.sel;
                    if (wait_states == 0) begin
                        // Zero wait states: read straight from the live
                        // address so data is ready in the ACK cycle.
                        state_d  = ACK;
                        arr_re   = !bus.we;
                        arr_radr = bus_idx;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = ws_load;
                    end
                end
            end
            WAIT: begin
                if (!bus.cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ACK;
                    arr_re  = !we_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ack_d = (state_d == ACK);
    end

    // Write commits on the edge leaving ACK; a reset in ACK drops it.
    assign arr_we = (state_q == ACK) && we_q && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
        end
    end

    wb_sram_array #(
        .dat_width (dat_width),
        .sel_width (sel_width),
        .depth     (depth)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (arr_we),
        .be    (sel_q),
        .wadr  (idx_q),
        .wdat  (dat_q),
        .re    (arr_re && !reset),
        .radr  (arr_radr),
        .rdat  (arr_rdat)
    );

    // The array's read flop is the datrd register: it is zero outside ACK
    // and on write acknowledges because re is only raised for reads.
    assign bus.datrd = arr_rdat;
    assign bus.ack   = ack_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
module tb_wb_sram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic [31:0] t_adr = '0;
    logic [31:0] t_dat = '0;
    logic [3:0]  t_sel = '0;
    logic        t_we  = 1'b0;
    logic        t_stb = 1'b0;
    logic        t_cyc = 1'b0;
    int          t_dut = 0;

    int total = 0;
    int bad   = 0;

    wishbone_bus_if if_a ();
    wishbone_bus_if if_b ();
    wishbone_bus_if if_c ();

    assign if_a.adr = t_adr;  assign if_a.datwr = t_dat;  assign if_a.sel = t_sel;  assign if_a.we = t_we;
    assign if_b.adr = t_adr;  assign if_b.datwr = t_dat;  assign if_b.sel = t_sel;  assign if_b.we = t_we;
    assign if_c.adr = t_adr;  assign if_c.datwr = t_dat;  assign if_c.sel = t_sel;  assign if_c.we = t_we;
    assign if_a.cyc = t_cyc && (t_dut == 0);  assign if_a.stb = t_stb && (t_dut == 0);
    assign if_b.cyc = t_cyc && (t_dut == 1);  assign if_b.stb = t_stb && (t_dut == 1);
    assign if_c.cyc = t_cyc && (t_dut == 2);  assign if_c.stb = t_stb && (t_dut == 2);

    // A: 1 wait state, base 0.  B: 3 wait states, base 0x1000.  C: 0 wait states, base 0.
    wb_sram_slave #(.adr_width(32), .dat_width(32), .sel_width(4), .depth(256),
                    .wait_states(1), .base_adr(32'h0000_0000))
        u_a (.clock(clk), .reset(rst), .bus(if_a));
    wb_sram_slave #(.adr_width(32), .dat_width(32), .sel_width(4), .depth(256),
                    .wait_states(3), .base_adr(32'h0000_1000))
        u_b (.clock(clk), .reset(rst), .bus(if_b));
    wb_sram_slave #(.adr_width(32), .dat_width(32), .sel_width(4), .depth(256),
                    .wait_states(0), .base_adr(32'h0000_0000))
        u_c (.clock(clk), .reset(rst), .bus(if_c));

    logic        ack_v [3];
    logic [31:0] rd_v  [3];
    assign ack_v[0] = if_a.ack;  assign rd_v[0] = if_a.datrd;
    assign ack_v[1] = if_b.ack;  assign rd_v[1] = if_b.datrd;
    assign ack_v[2] = if_c.ack;  assign rd_v[2] = if_c.datrd;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    // One full transaction. Waits one idle cycle first, so the slave is in IDLE
    // when the request is presented. lat = negedges from request to ack (0 = timeout).
    task automatic do_txn(input int dut, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input bit drop_stb,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        t_dut = dut; t_we = we; t_adr = adr; t_dat = dat; t_sel = sel;
        t_cyc = 1'b1; t_stb = 1'b1;
        lat = 0;
        rd  = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (drop_stb) t_stb = 1'b0;
            if (ack_v[dut]) begin
                lat = i;
                rd  = rd_v[dut];
                break;
            end
            check("datrd zero before ack", rd_v[dut], 32'h0);
        end
        t_cyc = 1'b0; t_stb = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t tbl [14];

    // Reference memory for the random phase on instance A: plain word array.
    logic [31:0] mdl [256];

    function automatic int word_of(input logic [31:0] adr, input logic [31:0] base);
        logic [31:0] off;
        off = adr - base;
        return int'((off / 4) % 256);
    endfunction

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          seen;

        tbl[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        2};
        tbl[1]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEEF, 2};
        tbl[2]  = '{1'b1, 32'h020, 32'h11223344, 4'hF, 32'h0,        2};
        tbl[3]  = '{1'b1, 32'h020, 32'hAABBCCDD, 4'h5, 32'h0,        2};
        tbl[4]  = '{1'b0, 32'h020, 32'h0,        4'hF, 32'h11BB33DD, 2};
        tbl[5]  = '{1'b0, 32'h013, 32'h0,        4'hF, 32'hDEADBEEF, 2};
        tbl[6]  = '{1'b1, 32'h010, 32'h99000000, 4'h8, 32'h0,        2};
        tbl[7]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'h99ADBEEF, 2};
        tbl[8]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        2};
        tbl[9]  = '{1'b1, 32'h3FC, 32'h12345678, 4'h0, 32'h0,        2};
        tbl[10] = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'hCAFEF00D, 2};
        tbl[11] = '{1'b0, 32'h7FC, 32'h0,        4'hF, 32'hCAFEF00D, 2};
        tbl[12] = '{1'b1, 32'h004, 32'hA5A5A5A5, 4'hF, 32'h0,        2};
        tbl[13] = '{1'b0, 32'h004, 32'h0,        4'hF, 32'hA5A5A5A5, 2};

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset ack", 32'(ack_v[d]), 32'h0);
            check("reset datrd", rd_v[d], 32'h0);
        end
        rst = 1'b0;

        // Table vectors on A
        for (int i = 0; i < 14; i++) begin
            do_txn(0, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, 1'b0, rd, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("vec%0d datrd", i), rd, tbl[i].exp_rd);
        end

        // Reset while A sits in WAIT on a write to 0x4
        @(negedge clk);
        t_dut = 0; t_we = 1'b1; t_adr = 32'h4; t_dat = 32'h0; t_sel = 4'hF;
        t_cyc = 1'b1; t_stb = 1'b1;
        @(negedge clk);
        rst = 1'b1; t_cyc = 1'b0; t_stb = 1'b0;
        @(negedge clk);
        check("reset in wait ack", 32'(ack_v[0]), 32'h0);
        rst = 1'b0;
        do_txn(0, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, rd, lat);
        check("after reset latency", 32'(lat), 32'd2);
        check("after reset old data", rd, 32'hA5A5A5A5);

        // B: base offset and index wrap
        do_txn(1, 1'b1, 32'h1000, 32'h5, 4'hF, 1'b0, rd, lat);
        check("base write latency", 32'(lat), 32'd4);
        do_txn(1, 1'b0, 32'h1400, 32'h0, 4'hF, 1'b0, rd, lat);
        check("wrap read latency", 32'(lat), 32'd4);
        check("wrap read data", rd, 32'h5);

        // B: abort by dropping cyc during WAIT
        do_txn(1, 1'b1, 32'h8, 32'h0, 4'hF, 1'b0, rd, lat);
        check("abort preload latency", 32'(lat), 32'd4);
        @(negedge clk);
        t_dut = 1; t_we = 1'b1; t_adr = 32'h8; t_dat = 32'hFFFFFFFF; t_sel = 4'hF;
        t_cyc = 1'b1; t_stb = 1'b1;
        @(negedge clk);
        t_cyc = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_v[1]) seen = 1'b1;
        end
        t_stb = 1'b0;
        check("abort no ack", 32'(seen), 32'h0);
        do_txn(1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, rd, lat);
        check("abort read data", rd, 32'h0);

        // B: stb dropped mid-wait with cyc still high still completes
        do_txn(1, 1'b1, 32'h100C, 32'h13579BDF, 4'hF, 1'b1, rd, lat);
        check("stb drop latency", 32'(lat), 32'd4);
        do_txn(1, 1'b0, 32'h100C, 32'h0, 4'hF, 1'b0, rd, lat);
        check("stb drop read data", rd, 32'h13579BDF);

        // C: zero wait states, stb held over two reads
        do_txn(2, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, 1'b0, rd, lat);
        check("ws0 write latency", 32'(lat), 32'd1);
        @(negedge clk);
        t_dut = 2; t_we = 1'b0; t_adr = 32'h40; t_sel = 4'hF;
        t_cyc = 1'b1; t_stb = 1'b1;
        @(negedge clk);
        check("held N+1 ack", 32'(ack_v[2]), 32'h1);
        check("held N+1 datrd", rd_v[2], 32'h0BADF00D);
        @(negedge clk);
        check("held N+2 ack", 32'(ack_v[2]), 32'h0);
        check("held N+2 datrd", rd_v[2], 32'h0);
        @(negedge clk);
        check("held N+3 ack", 32'(ack_v[2]), 32'h1);
        check("held N+3 datrd", rd_v[2], 32'h0BADF00D);
        t_cyc = 1'b0; t_stb = 1'b0;
        @(negedge clk);
        check("held end ack", 32'(ack_v[2]), 32'h0);

        // Random traffic on A over words 64..79, checked against mdl
        for (int k = 0; k < 16; k++) begin
            logic [31:0] v;
            v = $urandom;
            do_txn(0, 1'b1, 32'h100 + 32'(4 * k), v, 4'hF, 1'b0, rd, lat);
            mdl[word_of(32'h100 + 32'(4 * k), 32'h0)] = v;
        end
        for (int n = 0; n < 80; n++) begin
            logic        w;
            logic [31:0] a, v, exp;
            logic [3:0]  s;
            int          wi;
            w  = 1'($urandom_range(1));
            a  = 32'h100 + 32'(4 * $urandom_range(15)) + 32'($urandom_range(3));
            v  = $urandom;
            s  = 4'($urandom_range(15));
            wi = word_of(a, 32'h0);
            do_txn(0, w, a, v, s, 1'b0, rd, lat);
            if (w) begin
                for (int b = 0; b < 4; b++) if (s[b]) mdl[wi][8*b +: 8] = v[8*b +: 8];
                exp = 32'h0;
            end else begin
                exp = mdl[wi];
            end
            check($sformatf("rand%0d latency", n), 32'(lat), 32'd2);
            check($sformatf("rand%0d datrd", n), rd, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
